// File: rtl/ddr3_cmd_scheduler.sv
// DDR3 command scheduler: sequences one write job and one read job as BL8
// commands on the shared controller app_* port. Direction is chosen by acquisition mode.
module ddr3_cmd_scheduler #(
  parameter int unsigned ADDR_W   = 26,
  parameter int unsigned CNT_W    = 23,
  parameter int unsigned ADDR_INC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acq_enabled,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] wr_base_addr,
  input  logic [CNT_W-1:0]  wr_burst_count,
  input  logic              wr_data_avail,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base_addr,
  input  logic [CNT_W-1:0]  rd_burst_count,
  input  logic              rd_space_avail,
  output logic [ADDR_W:0]   app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic              wr_cmd_accepted,
  output logic              rd_cmd_accepted,
  output logic              wr_busy,
  output logic              rd_busy,
  output logic              wr_done,
  output logic              rd_done
);

  typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD} state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [CNT_W-1:0]  wr_rem_q, rd_rem_q;
  logic [ADDR_W:0]   app_addr_q;
  logic [2:0]        app_cmd_q;
  logic              app_en_q;
  logic              wr_acc_q, rd_acc_q, wr_done_q, rd_done_q;

  logic              wr_elig_d, rd_elig_d;
  logic [ADDR_W-1:0] wr_addr_d, rd_addr_d;
  logic [CNT_W-1:0]  wr_rem_d, rd_rem_d;

  // Eligibility uses the live mode; a command already on the port ignores it.
  assign wr_elig_d = acq_enabled  && (wr_rem_q != '0) && wr_data_avail;
  assign rd_elig_d = !acq_enabled && (rd_rem_q != '0) && rd_space_avail;

  // Post-acceptance address/count; the adder wraps naturally at 2^ADDR_W.
  assign wr_addr_d = wr_addr_q + ADDR_W'(ADDR_INC);
  assign rd_addr_d = rd_addr_q + ADDR_W'(ADDR_INC);
  assign wr_rem_d  = wr_rem_q - CNT_W'(1);
  assign rd_rem_d  = rd_rem_q - CNT_W'(1);

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_rem_q   <= '0;
      rd_rem_q   <= '0;
      app_addr_q <= '0;
      app_cmd_q  <= CMD_WR;
      app_en_q   <= 1'b0;
      wr_acc_q   <= 1'b0;
      rd_acc_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      wr_acc_q  <= 1'b0;
      rd_acc_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;

      // A start is only honoured by an idle job; an empty job completes at once.
      if (wr_start && (wr_rem_q == '0)) begin
        wr_addr_q <= wr_base_addr;
        wr_rem_q  <= wr_burst_count;
        if (wr_burst_count == '0) wr_done_q <= 1'b1;
      end
      if (rd_start && (rd_rem_q == '0)) begin
        rd_addr_q <= rd_base_addr;
        rd_rem_q  <= rd_burst_count;
        if (rd_burst_count == '0) rd_done_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (wr_elig_d) begin
            state_q    <= WR_CMD;
            app_en_q   <= 1'b1;
            app_cmd_q  <= CMD_WR;
            app_addr_q <= {1'b0, wr_addr_q};
          end else if (rd_elig_d) begin
            state_q    <= RD_CMD;
            app_en_q   <= 1'b1;
            app_cmd_q  <= CMD_RD;
            app_addr_q <= {1'b0, rd_addr_q};
          end
        end
        WR_CMD: begin
          if (app_rdy) begin
            wr_addr_q <= wr_addr_d;
            wr_rem_q  <= wr_rem_d;
            wr_acc_q  <= 1'b1;
            if (wr_rem_d == '0) wr_done_q <= 1'b1;
            if ((wr_rem_d != '0) && acq_enabled && wr_data_avail) begin
              app_addr_q <= {1'b0, wr_addr_d};
            end else begin
              state_q  <= IDLE;
              app_en_q <= 1'b0;
            end
          end
        end
        RD_CMD: begin
          if (app_rdy) begin
            rd_addr_q <= rd_addr_d;
            rd_rem_q  <= rd_rem_d;
            rd_acc_q  <= 1'b1;
            if (rd_rem_d == '0) rd_done_q <= 1'b1;
            if ((rd_rem_d != '0) && !acq_enabled && rd_space_avail) begin
              app_addr_q <= {1'b0, rd_addr_d};
            end else begin
              state_q  <= IDLE;
              app_en_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          app_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign app_addr        = app_addr_q;
  assign app_cmd         = app_cmd_q;
  assign app_en          = app_en_q;
  assign wr_cmd_accepted = wr_acc_q;
  assign rd_cmd_accepted = rd_acc_q;
  assign wr_done         = wr_done_q;
  assign rd_done         = rd_done_q;
  assign wr_busy         = (wr_rem_q != '0);
  assign rd_busy         = (rd_rem_q != '0);

endmodule

// File: tb/tb_ddr3_cmd_scheduler.sv
// Self-checking bench for ddr3_cmd_scheduler: directed timing steps plus a
// randomized phase checked against a job-level model (next address, remaining count).
module tb_ddr3_cmd_scheduler;

  localparam int ADDR_W = 26;
  localparam int CNT_W  = 23;

  logic              clk = 1'b0;
  logic              reset;
  logic              acq_enabled;
  logic              wr_start, rd_start;
  logic [ADDR_W-1:0] wr_base_addr, rd_base_addr;
  logic [CNT_W-1:0]  wr_burst_count, rd_burst_count;
  logic              wr_data_avail, rd_space_avail;
  logic [ADDR_W:0]   app_addr;
  logic [2:0]        app_cmd;
  logic              app_en, app_rdy;
  logic              wr_cmd_accepted, rd_cmd_accepted;
  logic              wr_busy, rd_busy, wr_done, rd_done;

  ddr3_cmd_scheduler dut (
    .clk(clk), .reset(reset), .acq_enabled(acq_enabled),
    .wr_start(wr_start), .wr_base_addr(wr_base_addr), .wr_burst_count(wr_burst_count),
    .wr_data_avail(wr_data_avail),
    .rd_start(rd_start), .rd_base_addr(rd_base_addr), .rd_burst_count(rd_burst_count),
    .rd_space_avail(rd_space_avail),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .wr_cmd_accepted(wr_cmd_accepted), .rd_cmd_accepted(rd_cmd_accepted),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_done(wr_done), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Job-level reference: next expected address and commands still owed per direction.
  logic [ADDR_W-1:0] wr_next_m, rd_next_m;
  int wr_rem_m = 0, rd_rem_m = 0;
  int wr_hs = 0, rd_hs = 0, wr_acc_seen = 0, rd_acc_seen = 0;
  int wr_done_seen = 0, rd_done_seen = 0, wr_done_exp = 0, rd_done_exp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [ADDR_W-1:0] base, input int cnt);
    wr_start = 1'b1;
    wr_base_addr = base;
    wr_burst_count = CNT_W'(cnt);
    if (wr_rem_m == 0) begin
      wr_next_m = base;
      wr_rem_m  = cnt;
      if (cnt == 0) wr_done_exp++;
    end
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] base, input int cnt);
    rd_start = 1'b1;
    rd_base_addr = base;
    rd_burst_count = CNT_W'(cnt);
    if (rd_rem_m == 0) begin
      rd_next_m = base;
      rd_rem_m  = cnt;
      if (cnt == 0) rd_done_exp++;
    end
  endtask

  task automatic pulse();
    cyc();
    wr_start = 1'b0;
    rd_start = 1'b0;
  endtask

  task automatic wait_wr_done(input string tag, input int budget);
    int n = 0;
    while (wr_done !== 1'b1 && n < budget) begin cyc(); n++; end
    check(tag, wr_done, 1);
  endtask

  task automatic wait_rd_done(input string tag, input int budget);
    int n = 0;
    while (rd_done !== 1'b1 && n < budget) begin cyc(); n++; end
    check(tag, rd_done, 1);
  endtask

  task automatic wait_en(input string tag, input int budget);
    int n = 0;
    while (app_en !== 1'b1 && n < budget) begin cyc(); n++; end
    check(tag, app_en, 1);
  endtask

  task automatic clear_model();
    wr_rem_m = 0; rd_rem_m = 0;
    wr_hs = 0; rd_hs = 0; wr_acc_seen = 0; rd_acc_seen = 0;
    wr_done_seen = 0; rd_done_seen = 0; wr_done_exp = 0; rd_done_exp = 0;
  endtask

  // Port monitor: every handshake must match the model; stalled commands must hold.
  initial begin
    logic            prev_stall;
    logic [ADDR_W:0] prev_addr;
    logic [2:0]      prev_cmd;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_cmd   = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_en", app_en, 1);
          check("hold_addr", app_addr, prev_addr);
          check("hold_cmd", app_cmd, prev_cmd);
        end
        if (wr_cmd_accepted === 1'b1) wr_acc_seen++;
        if (rd_cmd_accepted === 1'b1) rd_acc_seen++;
        if (wr_done === 1'b1) wr_done_seen++;
        if (rd_done === 1'b1) rd_done_seen++;
        if (app_en === 1'b1 && app_rdy === 1'b1) begin
          if (app_cmd === 3'b000) begin
            check("wr_cmd_owed", wr_rem_m > 0, 1);
            check("wr_cmd_addr", app_addr, {1'b0, wr_next_m});
            wr_next_m = wr_next_m + ADDR_W'(8);
            wr_hs++;
            if (wr_rem_m > 0) begin
              wr_rem_m--;
              if (wr_rem_m == 0) wr_done_exp++;
            end
          end else begin
            check("rd_cmd_code", app_cmd, 3'b001);
            check("rd_cmd_owed", rd_rem_m > 0, 1);
            check("rd_cmd_addr", app_addr, {1'b0, rd_next_m});
            rd_next_m = rd_next_m + ADDR_W'(8);
            rd_hs++;
            if (rd_rem_m > 0) begin
              rd_rem_m--;
              if (rd_rem_m == 0) rd_done_exp++;
            end
          end
        end
        prev_stall = (app_en === 1'b1) && (app_rdy !== 1'b1);
        prev_addr  = app_addr;
        prev_cmd   = app_cmd;
      end
    end
  end

  initial begin
    int hs0;
    int n;
    reset = 1'b1;
    acq_enabled = 1'b0;
    wr_start = 1'b0; rd_start = 1'b0;
    wr_base_addr = '0; rd_base_addr = '0;
    wr_burst_count = '0; rd_burst_count = '0;
    wr_data_avail = 1'b0; rd_space_avail = 1'b0;
    app_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_app_en", app_en, 0);
    check("rst_app_addr", app_addr, 0);
    check("rst_app_cmd", app_cmd, 0);
    check("rst_pulses", {wr_cmd_accepted, rd_cmd_accepted, wr_done, rd_done}, 0);
    check("rst_busy", {wr_busy, rd_busy}, 0);
    reset = 1'b0;
    cyc();

    // Write job, back-to-back, start-to-command latency of two cycles.
    acq_enabled = 1'b1; wr_data_avail = 1'b1; app_rdy = 1'b1;
    set_wr(26'h100, 3);
    pulse();
    check("t1_n1_en", app_en, 0);
    check("t1_n1_busy", wr_busy, 1);
    cyc();
    check("t1_c0_en", app_en, 1);
    check("t1_c0_addr", app_addr, 27'h100);
    check("t1_c0_cmd", app_cmd, 3'b000);
    cyc();
    check("t1_c1_addr", app_addr, 27'h108);
    check("t1_c1_acc", wr_cmd_accepted, 1);
    cyc();
    check("t1_c2_en", app_en, 1);
    check("t1_c2_addr", app_addr, 27'h110);
    cyc();
    check("t1_end_en", app_en, 0);
    check("t1_end_done", wr_done, 1);
    check("t1_end_busy", wr_busy, 0);
    cyc();
    check("t1_done_once", wr_done, 0);

    // Controller stall on the second command.
    set_wr(26'h100, 3);
    pulse();
    cyc();
    check("t2_c0_addr", app_addr, 27'h100);
    cyc();
    app_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) app_rdy = 1'b1;
      check("t2_hold_addr", app_addr, 27'h108);
      check("t2_hold_en", app_en, 1);
      cyc();
    end
    check("t2_c2_addr", app_addr, 27'h110);
    cyc();
    check("t2_end_en", app_en, 0);
    check("t2_end_done", wr_done, 1);

    // Read job across the address wrap.
    acq_enabled = 1'b0; rd_space_avail = 1'b1;
    set_rd(26'h3FFFFF0, 3);
    pulse();
    cyc();
    check("t3_c0_addr", app_addr, 27'h3FFFFF0);
    check("t3_c0_cmd", app_cmd, 3'b001);
    cyc();
    check("t3_c1_addr", app_addr, 27'h3FFFFF8);
    cyc();
    check("t3_c2_addr", app_addr, 27'h0000000);
    check("t3_c2_en", app_en, 1);
    cyc();
    check("t3_end_en", app_en, 0);
    check("t3_end_done", rd_done, 1);

    // Mode drop with a write pending, then resume.
    acq_enabled = 1'b1;
    set_wr(26'h200, 4);
    set_rd(26'h1000, 4);
    pulse();
    check("t4_both_busy", {wr_busy, rd_busy}, 2'b11);
    cyc();
    check("t4_w0", app_addr, 27'h200);
    cyc();
    check("t4_w1", app_addr, 27'h208);
    cyc();
    app_rdy = 1'b0; acq_enabled = 1'b0;
    check("t4_w2", app_addr, 27'h210);
    cyc();
    check("t4_w2_held", app_addr, 27'h210);
    check("t4_w2_cmd", app_cmd, 3'b000);
    cyc();
    app_rdy = 1'b1;
    check("t4_w2_en", app_en, 1);
    cyc();
    check("t4_idle_gap", app_en, 0);
    wait_rd_done("t4_rd_done", 20);
    check("t4_wr_paused", wr_busy, 1);
    check("t4_rd_idle", rd_busy, 0);
    acq_enabled = 1'b1;
    cyc();
    wait_en("t4_resume_en", 10);
    check("t4_resume_addr", app_addr, 27'h218);
    check("t4_resume_cmd", app_cmd, 3'b000);
    wait_wr_done("t4_wr_done", 10);

    // Zero-count job and a start ignored while busy.
    cyc();
    set_wr(26'h500, 0);
    pulse();
    check("t5_zero_done", wr_done, 1);
    check("t5_zero_busy", wr_busy, 0);
    check("t5_zero_en", app_en, 0);
    cyc();
    check("t5_zero_no_cmd", app_en, 0);
    check("t5_zero_done_once", wr_done, 0);
    wr_data_avail = 1'b0;
    hs0 = wr_hs;
    set_wr(26'h600, 2);
    pulse();
    set_wr(26'h900, 5);
    pulse();
    check("t5_ign_en", app_en, 0);
    wr_data_avail = 1'b1;
    wait_en("t5_ign_go", 10);
    check("t5_ign_addr", app_addr, 27'h600);
    wait_wr_done("t5_ign_done", 10);
    check("t5_ign_cmds", wr_hs - hs0, 2);
    check("t5_ign_busy", wr_busy, 0);

    // Asynchronous reset in the middle of a burst.
    cyc();
    set_wr(26'h700, 8);
    pulse();
    cyc();
    cyc();
    check("t6_pre_en", app_en, 1);
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    check("t6_rst_en", app_en, 0);
    check("t6_rst_busy", wr_busy, 0);
    cyc();
    reset = 1'b0;
    cyc();
    set_wr(26'h800, 2);
    pulse();
    cyc();
    check("t6_new_en", app_en, 1);
    check("t6_new_addr", app_addr, 27'h800);
    wait_wr_done("t6_new_done", 10);

    // Randomized traffic, checked by the monitor against the job model.
    for (int i = 0; i < 2000; i++) begin
      app_rdy        = ($urandom % 4) != 0;
      wr_data_avail  = ($urandom % 8) != 0;
      rd_space_avail = ($urandom % 8) != 0;
      if ($urandom % 40 == 0) acq_enabled = ~acq_enabled;
      if ($urandom % 12 == 0) set_wr(ADDR_W'($urandom), int'($urandom % 6));
      if ($urandom % 12 == 0) set_rd(ADDR_W'($urandom), int'($urandom % 6));
      cyc();
      wr_start = 1'b0;
      rd_start = 1'b0;
    end
    app_rdy = 1'b1; wr_data_avail = 1'b1; rd_space_avail = 1'b1;
    acq_enabled = 1'b1;
    n = 0;
    while (wr_busy !== 1'b0 && n < 200) begin cyc(); n++; end
    check("rnd_wr_drain", wr_busy, 0);
    acq_enabled = 1'b0;
    n = 0;
    while (rd_busy !== 1'b0 && n < 200) begin cyc(); n++; end
    check("rnd_rd_drain", rd_busy, 0);
    repeat (3) cyc();
    check("rnd_wr_acc_pulses", wr_acc_seen, wr_hs);
    check("rnd_rd_acc_pulses", rd_acc_seen, rd_hs);
    check("rnd_wr_dones", wr_done_seen, wr_done_exp);
    check("rnd_rd_dones", rd_done_seen, rd_done_exp);
    check("rnd_wr_owed", wr_rem_m, 0);
    check("rnd_rd_owed", rd_rem_m, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr3_cmd_scheduler.md
# ddr3_cmd_scheduler

Sequences DDR3 memory-controller address/command traffic for the digitizer. Accepts one write job (ADC fill → DDR3) and one read job (DDR3 → readout) as base address plus burst count. Issues one BL8 command per burst on the controller's app_addr/app_cmd/app_en port, honouring app_rdy. Arbitrates by acquisition mode, so the write and read address generators share the single command port without upstream muxing.

## Interface
- ADDR_W, 26, DDR3 column-unit address width; app_addr is ADDR_W+1 with MSB tied 0
- CNT_W, 23, burst-count width
- ADDR_INC, 8, address step per accepted command (BL8)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- acq_enabled  in  1  1 = write mode (write commands eligible); 0 = read mode
- wr_start  in  1  one-cycle pulse; load write job
- wr_base_addr  in  ADDR_W  first write address
- wr_burst_count  in  CNT_W  number of write commands in job
- wr_data_avail  in  1  ADC FIFO holds ≥1 unclaimed burst
- rd_start  in  1  one-cycle pulse; load read job
- rd_base_addr  in  ADDR_W  first read address
- rd_burst_count  in  CNT_W  number of read commands in job
- rd_space_avail  in  1  readout FIFO can absorb ≥1 burst
- app_addr  out  ADDR_W+1  registered command address
- app_cmd  out  3  registered; 3'b000 write, 3'b001 read
- app_en  out  1  registered command strobe
- app_rdy  in  1  controller accepts command this cycle when app_en=1
- wr_cmd_accepted  out  1  pulse: one write command accepted (claims one FIFO burst)
- rd_cmd_accepted  out  1  pulse: one read command accepted
- wr_busy / rd_busy  out  1  job's remaining count ≠ 0
- wr_done / rd_done  out  1  one-cycle pulse when job's last command is accepted

## Operation
- Per direction: registers addr (ADDR_W) and remaining (CNT_W). On start with remaining = 0, load base/count; start while remaining ≠ 0 is ignored.
- Start with count 0: no command; done pulses the cycle after start.
- FSM states: IDLE, WR_CMD, RD_CMD.
- IDLE→WR_CMD when acq_enabled & wr remaining≠0 & wr_data_avail.
- IDLE→RD_CMD when ~acq_enabled & rd remaining≠0 & rd_space_avail.
- Mode selects the direction, so both transitions are mutually exclusive.
- WR_CMD/RD_CMD: app_en=1, app_cmd per state, app_addr = {1'b0, addr}.
- Address and command are held stable until app_rdy=1.
- On acceptance: remaining−1; addr+ADDR_INC modulo 2^ADDR_W (wraps 0x3FFFFF8→0x0000000); accepted pulse.
- After acceptance, stay in state (back-to-back) if new remaining≠0 and the eligibility condition still holds. Otherwise return to IDLE with app_en=0.
- acq_enabled toggling while app_en=1: the command in flight is held unchanged until accepted. The mode takes effect only at the next IDLE decision.
- A job paused by mode change keeps its addr/remaining and resumes when its mode returns.
- wr_start and rd_start in the same cycle: both jobs load independently.

## Timing
- Reset values: app_en 0, app_addr 0, app_cmd 3'b000, all pulses 0, busy 0, state IDLE, counters 0.
- Reset mid-command: app_en drops asynchronously; the job is lost.
- start in cycle N → registers loaded at edge ending N → app_en high in cycle N+2 if eligible.
- Back-to-back: one command per cycle while app_rdy=1 and eligibility holds.
- Non-continuing acceptance costs one IDLE cycle.
- Accepted/done pulses are registered and appear in the cycle after the app_rdy handshake.
- busy falls in the same cycle as done.

## Test plan
- Write job, base 0x100, count 3, acq_enabled=1, wr_data_avail=1, app_rdy=1 → app_en high 3 consecutive cycles, addrs 0x100/0x108/0x110, cmd 000; 3 wr_cmd_accepted; wr_done once.
- Same job with app_rdy low for 4 cycles on the 2nd command → addr 0x108 held 5 cycles; total still 3 commands.
- Read job, base 0x3FFFFF0, count 3, acq_enabled=0 → addrs 0x3FFFFF0, 0x3FFFFF8, 0x0000000; cmd 001; rd_done.
- Both jobs count 4; acq_enabled=1; drop it after 2 writes accepted, while the 3rd is pending → 3rd write completes, then reads run. Raising acq_enabled resumes the 4th write at the correct addr.
- Count 0 start → no app_en, done pulse at N+1. Second wr_start while busy → ignored, addresses unaffected.
- Reset asserted mid-burst → app_en 0 immediately, busy 0. A new job after release starts from its base address.
